// File: rtl/tt_um_mac.sv
// tt_um_mac: instruction-driven 6x6 multiply-accumulate engine.
// One 8-bit instruction per clock on ui_in ([7:6] opcode, [5:0] operand).
// The 16-bit result register is presented on uo_out (low) / uio_out (high).
// rst_n keeps its historical name but is a synchronous, active-high reset.
module tt_um_mac (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] acc_debug,
  output logic [3:0] state_debug
);

  // State codes are visible on state_debug, so they are fixed explicitly.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_LOAD  = 4'd1,
    ST_MAC   = 4'd2,
    ST_STORE = 4'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_LOAD  = 2'b01,
    OP_MAC   = 2'b10,
    OP_STORE = 2'b11
  } opcode_t;

  state_t      state, state_next;
  logic [5:0]  a_reg, a_next;
  logic [15:0] acc, acc_next;
  logic [15:0] res, res_next;

  opcode_t     opcode;
  logic [5:0]  operand;
  logic [11:0] product;

  // uio_in has no function; it is folded into a sink so nothing depends on it.
  logic unused_inputs;
  assign unused_inputs = &{1'b0, uio_in};

  assign opcode  = opcode_t'(ui_in[7:6]);
  assign operand = ui_in[5:0];

  // Unsigned 6x6 multiply; full 12-bit product, no truncation.
  assign product = a_reg * operand;

  // Decode and execute the current instruction into next-register values.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_next = state;
    a_next     = a_reg;
    acc_next   = acc;
    res_next   = res;

    if (ena) begin
      unique case (opcode)
        OP_NOP: begin
          state_next = ST_IDLE;
        end
        OP_LOAD: begin
          state_next = ST_LOAD;
          a_next     = operand;
        end
        OP_MAC: begin
          state_next = ST_MAC;
          // Wraps modulo 2^16 by construction of the 16-bit sum.
          acc_next   = acc + {4'b0000, product};
        end
        OP_STORE: begin
          state_next = ST_STORE;
          // RES captures the pre-edge accumulator even on store-and-clear.
          res_next   = acc;
          if (operand[0]) acc_next = '0;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State register; synchronous reset has priority over ena and instructions.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath registers: operand A, accumulator and result.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      a_reg <= '0;
      acc   <= '0;
      res   <= '0;
    end else begin
      a_reg <= a_next;
      acc   <= acc_next;
      res   <= res_next;
    end
  end

  // Outputs come straight from registers; no combinational path from ui_in.
  assign uo_out      = res[7:0];
  assign uio_out     = res[15:8];
  assign uio_oe      = 8'hFF;
  assign acc_debug   = acc[7:0];
  assign state_debug = state;

endmodule

// File: tb/tb_tt_um_mac.sv
// Self-checking bench for tt_um_mac: directed vector table, a hand-written
// long MAC run, then randomized instructions against a behavioural model.
module tb_tt_um_mac;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic [7:0] acc_debug;
  logic [3:0] state_debug;

  int n_compared   = 0;
  int n_mismatched = 0;

  tt_um_mac dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .ui_in       (ui_in),
    .uio_in      (uio_in),
    .uo_out      (uo_out),
    .uio_out     (uio_out),
    .uio_oe      (uio_oe),
    .acc_debug   (acc_debug),
    .state_debug (state_debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] ui;
    logic [7:0] exp_uo;
    logic [7:0] exp_uio;
    logic [7:0] exp_acc;
    logic [3:0] exp_state;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic add(input logic rst, input logic en, input logic [7:0] ui,
                     input logic [7:0] uo, input logic [7:0] uio,
                     input logic [7:0] acc, input logic [3:0] st);
    vec_t v;
    v.rst = rst; v.en = en; v.ui = ui;
    v.exp_uo = uo; v.exp_uio = uio; v.exp_acc = acc; v.exp_state = st;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs, then sample just after the rising edge.
  task automatic step(input logic rst, input logic en, input logic [7:0] ui);
    rst_n  = rst;
    ena    = en;
    ui_in  = ui;
    uio_in = 8'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] uo, input logic [7:0] uio,
                           input logic [7:0] acc, input logic [3:0] st);
    check({tag, ".uo_out"},      16'(uo_out),      16'(uo));
    check({tag, ".uio_out"},     16'(uio_out),     16'(uio));
    check({tag, ".acc_debug"},   16'(acc_debug),   16'(acc));
    check({tag, ".state_debug"}, 16'(state_debug), 16'(st));
    check({tag, ".uio_oe"},      16'(uio_oe),      16'hFF);
  endtask

  // Behavioural reference: plain integer arithmetic on the architectural registers.
  int m_a, m_acc, m_res, m_state;

  task automatic model_step(input logic rst, input logic en, input logic [7:0] ui);
    int op, arg, old_acc;
    op  = int'(ui) / 64;
    arg = int'(ui) % 64;
    if (rst) begin
      m_a = 0; m_acc = 0; m_res = 0; m_state = 0;
    end else if (en) begin
      old_acc = m_acc;
      m_state = op;
      if (op == 1) m_a = arg;
      if (op == 2) m_acc = (m_acc + m_a * arg) % 65536;
      if (op == 3) begin
        m_res = old_acc;
        if (arg % 2 == 1) m_acc = 0;
      end
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;

    // Reset with a live instruction on ui_in, then the example program.
    add(1, 1, 8'h82, 8'h00, 8'h00, 8'h00, 4'd0);
    add(1, 1, 8'hC1, 8'h00, 8'h00, 8'h00, 4'd0);
    add(0, 1, 8'h41, 8'h00, 8'h00, 8'h00, 4'd1);
    add(0, 1, 8'h42, 8'h00, 8'h00, 8'h00, 4'd1);
    add(0, 1, 8'h81, 8'h00, 8'h00, 8'h02, 4'd2);
    add(0, 1, 8'h82, 8'h00, 8'h00, 8'h06, 4'd2);
    add(0, 1, 8'hC0, 8'h06, 8'h00, 8'h06, 4'd3);
    add(0, 1, 8'h44, 8'h06, 8'h00, 8'h06, 4'd1);
    add(0, 1, 8'h83, 8'h06, 8'h00, 8'h12, 4'd2);
    add(0, 1, 8'hC0, 8'h12, 8'h00, 8'h12, 4'd3);
    add(0, 1, 8'h00, 8'h12, 8'h00, 8'h12, 4'd0);
    // Store-and-clear, then a plain store of the cleared accumulator.
    add(0, 1, 8'hC1, 8'h12, 8'h00, 8'h00, 4'd3);
    add(0, 1, 8'hC0, 8'h00, 8'h00, 8'h00, 4'd3);
    // Largest operands and high result byte.
    add(0, 1, 8'h7F, 8'h00, 8'h00, 8'h00, 4'd1);
    add(0, 1, 8'hBF, 8'h00, 8'h00, 8'h81, 4'd2);
    add(0, 1, 8'hC0, 8'h81, 8'h0F, 8'h81, 4'd3);
    add(0, 1, 8'hFF, 8'h81, 8'h0F, 8'h00, 4'd3);
    // ena gating: build ACC=06, A=2, then hold for three cycles.
    add(1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0);
    add(0, 1, 8'h42, 8'h00, 8'h00, 8'h00, 4'd1);
    add(0, 1, 8'h83, 8'h00, 8'h00, 8'h06, 4'd2);
    add(0, 0, 8'h82, 8'h00, 8'h00, 8'h06, 4'd2);
    add(0, 0, 8'hC1, 8'h00, 8'h00, 8'h06, 4'd2);
    add(0, 0, 8'h82, 8'h00, 8'h00, 8'h06, 4'd2);
    add(0, 1, 8'h82, 8'h00, 8'h00, 8'h0A, 4'd2);
    // Reset mid-program: the MAC on ui_in at the reset edge is discarded.
    add(1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0);
    add(0, 1, 8'h42, 8'h00, 8'h00, 8'h00, 4'd1);
    add(0, 1, 8'h83, 8'h00, 8'h00, 8'h06, 4'd2);
    add(0, 1, 8'hC0, 8'h06, 8'h00, 8'h06, 4'd3);
    add(1, 1, 8'h82, 8'h00, 8'h00, 8'h00, 4'd0);
    add(0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 4'd0);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].ui);
      check_all($sformatf("vec%0d", i), vecs[i].exp_uo, vecs[i].exp_uio,
                vecs[i].exp_acc, vecs[i].exp_state);
    end

    // Accumulator wrap: 17 x (63*63) from zero = 0x0791 mod 2^16.
    step(0, 1, 8'h7F);
    for (int k = 0; k < 17; k++) step(0, 1, 8'hBF);
    check("wrap17.acc_debug", 16'(acc_debug), 16'h0091);
    step(0, 1, 8'hC0);
    check("wrap17.uo_out",  16'(uo_out),  16'h0091);
    check("wrap17.uio_out", 16'(uio_out), 16'h0007);

    // Randomized instruction stream against the reference model.
    step(1, 1, 8'h00);
    model_step(1, 1, 8'h00);
    for (int n = 0; n < 3000; n++) begin
      logic       r_rst, r_en;
      logic [7:0] r_ui;
      r_rst = ($urandom_range(0, 99) == 0);
      r_en  = ($urandom_range(0, 9) != 0);
      r_ui  = 8'($urandom);
      // Bias toward MAC so the accumulator climbs high enough to wrap.
      if ($urandom_range(0, 3) == 0) r_ui[7:6] = 2'b10;
      step(r_rst, r_en, r_ui);
      model_step(r_rst, r_en, r_ui);
      check_all($sformatf("rnd%0d", n), 8'(m_res % 256), 8'(m_res / 256),
                8'(m_acc % 256), 4'(m_state));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
